// File: rtl/apb_pkg.sv
// Shared types and constants for the CPU-to-APB3 bridge.
// State encoding, funct3 access codes, default map, legality helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int          DEF_SLAVES  = 4;
  localparam logic [31:0] DEF_BASE    = 32'h1000_0000;
  localparam logic [31:0] DEF_SIZE    = 32'h0000_1000;
  localparam int          DEF_TIMEOUT = 256;

  // Access size/sign code is known, store is not unsigned,
  // and the address is naturally aligned for the size.
  function automatic logic req_legal(
    input logic [2:0] f3,
    input logic       we,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !a[0];
      F3_HU:   ok = !we && !a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane placement for stores and extraction/extension for loads.
// Ports: f3/we/a describe the access; wdata/rdata raw; pwdata/pstrb/rdext.
module apb_lane_align
  import apb_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [31:0] rdext
);

  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    pwdata = '0;
    pstrb  = '0;
    rdext  = rdata;
    rb     = 8'(rdata >> {a, 3'b000});
    rh     = a[1] ? rdata[31:16] : rdata[15:0];

    case (f3[1:0])
      2'b00: begin
        pstrb  = 4'b0001 << a;
        pwdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        pstrb  = 4'b0011 << a;
        pwdata = {2{wdata[15:0]}};
      end
      default: begin
        pstrb  = 4'b1111;
        pwdata = wdata;
      end
    endcase

    // Loads drive no lanes.
    if (!we) begin
      pstrb  = '0;
      pwdata = '0;
    end

    case (f3)
      F3_B:    rdext = {{24{rb[7]}}, rb};
      F3_BU:   rdext = {24'b0, rb};
      F3_H:    rdext = {{16{rh[15]}}, rh};
      F3_HU:   rdext = {16'b0, rh};
      default: rdext = rdata;
    endcase
  end

endmodule

// File: rtl/apb_master.sv
// Bridges one CPU load/store request into one APB3 transfer.
// Ports: bus* CPU side (req/we/addr/strb/data, ready/err pulse); P* APB side.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES  = DEF_SLAVES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE,
  parameter logic [31:0] SLAVE_SIZE  = DEF_SIZE,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     busReq,
  input  logic                     busWe,
  input  logic [31:0]              busAddr,
  input  logic [2:0]               strb,
  input  logic [31:0]              busWData,
  output logic [31:0]              busRData,
  output logic                     busReady,
  output logic                     busErr,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t        state, state_n;
  logic [SW-1:0] sel_q;
  logic [2:0]    f3_q;
  logic [1:0]    a_q;
  logic [31:0]   wd_q;
  logic          err_q;
  logic [TW-1:0] timer;

  logic [31:0] off, idx;
  logic        hit, legal, accept;
  logic [31:0] rd_sel, rd_ext;
  logic        rdy_sel, err_sel, tmo;

  // No wrap: the subtraction is only trusted when addr >= base.
  assign off    = busAddr - BASE_ADDR;
  assign idx    = off / SLAVE_SIZE;
  assign hit    = (busAddr >= BASE_ADDR) && (idx < 32'(NUM_SLAVES));
  assign legal  = hit && req_legal(strb, busWe, busAddr[1:0]);
  // While an error pulse is out the CPU still holds the old request.
  assign accept = (state == IDLE) && busReq && !err_q;

  assign tmo = (TIMEOUT_CYC != 0) && (timer == TW'(TIMEOUT_CYC - 1));

  assign PSEL    = (state != IDLE) ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign PENABLE = (state == ACCESS);

  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    err_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SW'(i) == sel_q) begin
        rd_sel  = PRDATA[32*i +: 32];
        rdy_sel = PREADY[i];
        err_sel = PSLVERR[i];
      end
    end
  end

  apb_lane_align u_lane (
    .f3     (f3_q),
    .we     (PWRITE),
    .a      (a_q),
    .wdata  (wd_q),
    .rdata  (rd_sel),
    .pwdata (PWDATA),
    .pstrb  (PSTRB),
    .rdext  (rd_ext)
  );

  always_comb begin
    state_n  = state;
    busReady = 1'b0;
    busErr   = 1'b0;
    busRData = '0;
    unique case (state)
      IDLE: begin
        busReady = err_q;
        busErr   = err_q;
        if (accept && legal) state_n = SETUP;
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (rdy_sel) begin
          busReady = 1'b1;
          busErr   = err_sel;
          if (!err_sel && !PWRITE) busRData = rd_ext;
          state_n  = IDLE;
        end else if (tmo) begin
          busReady = 1'b1;
          busErr   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sel_q  <= '0;
      f3_q   <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      err_q  <= 1'b0;
      timer  <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= accept && !legal;
      timer <= (state == ACCESS) ? timer + 1'b1 : '0;
      if (accept && legal) begin
        sel_q  <= idx[SW-1:0];
        f3_q   <= strb;
        a_q    <= busAddr[1:0];
        wd_q   <= busWData;
        PADDR  <= {busAddr[31:2], 2'b00};
        PWRITE <= busWe;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed table, chained and reset sequences,
// then random traffic against an arithmetic reference model.
module tb_apb_master;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] SIZE  = 32'h0000_1000;
  localparam int          TMO   = 4;
  localparam logic [31:0] NOISE = 32'h5A5A_C3C3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        slverr;
    int          lat;
    logic        err;
    logic [31:0] erd;
    logic [3:0]  psel;
    logic [3:0]  pstrb;
    logic [31:0] pwd;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         busReq, busWe;
  logic [31:0]  busAddr, busWData, busRData;
  logic [2:0]   strb;
  logic         busReady, busErr;
  logic [31:0]  PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL, PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic [31:0] s_rd;
  int          s_wait;
  logic        s_err;
  int          acnt = 0;

  int checks = 0;
  int errors = 0;

  vec_t tbl[18];

  always #5 clk = ~clk;

  apb_master #(
    .NUM_SLAVES  (4),
    .BASE_ADDR   (BASE),
    .SLAVE_SIZE  (SIZE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busReq   (busReq),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .strb     (strb),
    .busWData (busWData),
    .busRData (busRData),
    .busReady (busReady),
    .busErr   (busErr),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Slave model: the selected slave answers after s_wait access cycles;
  // unselected slaves shout ready/error/noise to prove they are ignored.
  always @(posedge clk) acnt <= PENABLE ? acnt + 1 : 0;

  always_comb begin
    PRDATA  = {4{NOISE}};
    PREADY  = '1;
    PSLVERR = '1;
    for (int k = 0; k < 4; k++) begin
      if (PSEL[k]) begin
        PRDATA[32*k +: 32] = s_rd;
        PREADY[k]          = PENABLE && (acnt == s_wait);
        PSLVERR[k]         = s_err;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t        r;
    longint      off;
    int          sz;
    logic [31:0] m, x;
    bit          ok;
    r       = v;
    r.psel  = '0;
    r.pstrb = '0;
    r.pwd   = '0;
    r.erd   = '0;
    sz  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = longint'(v.addr) - longint'(BASE);
    ok  = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
          && !(v.we && v.f3[2])
          && (v.addr % sz == 0)
          && (off >= 0) && (off / longint'(SIZE) < 4);
    if (!ok) begin
      r.lat = 2;
      r.err = 1'b1;
      return r;
    end
    r.psel = 4'(1 << (off / longint'(SIZE)));
    if (v.we) begin
      r.pstrb = 4'(((1 << sz) - 1) << v.addr[1:0]);
      if (sz == 1)      r.pwd = {24'b0, v.wd[7:0]} * 32'h0101_0101;
      else if (sz == 2) r.pwd = {16'b0, v.wd[15:0]} * 32'h0001_0001;
      else              r.pwd = v.wd;
    end
    if (v.waits >= TMO) begin
      r.lat = 2 + TMO;
      r.err = 1'b1;
      return r;
    end
    r.lat = 3 + v.waits;
    r.err = v.slverr;
    if (!v.we && !v.slverr) begin
      x = v.rd >> (8 * v.addr[1:0]);
      m = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
      x = x & m;
      if (!v.f3[2] && sz < 4 && x[8*sz-1]) x = x | ~m;
      r.erd = x;
    end
    return r;
  endfunction

  // Called at a falling edge; cycle 1 is the cycle the request appears.
  task automatic run_vec(input vec_t v, input string tag, input bit keep);
    int          lat;
    bit          seen;
    logic        e;
    logic [31:0] rdv, pwd, pad;
    logic [3:0]  pso, pst;
    busReq   = 1'b1;
    busWe    = v.we;
    busAddr  = v.addr;
    strb     = v.f3;
    busWData = v.wd;
    s_rd     = v.rd;
    s_wait   = v.waits;
    s_err    = v.slverr;
    lat = 0; seen = 0; e = 0; rdv = 0;
    pwd = 0; pad = 0; pso = 0; pst = 0;
    while (!seen && lat < 40) begin
      #1;
      lat++;
      pso |= PSEL;
      if (PENABLE) begin
        pst = PSTRB;
        pwd = PWDATA;
        pad = PADDR;
      end
      if (busReady) begin
        seen = 1;
        e    = busErr;
        rdv  = busRData;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s busReady never arrived act=none exp=lat%0d",
               tag, v.lat);
    end else begin
      chk({tag, " latency"}, lat, v.lat);
      chk({tag, " busErr"}, e, v.err);
      chk({tag, " PSEL"}, pso, v.psel);
      if (v.psel != 0) begin
        chk({tag, " PSTRB"}, pst, v.pstrb);
        chk({tag, " PADDR"}, pad, v.addr & 32'hFFFF_FFFC);
        if (v.we) chk({tag, " PWDATA"}, pwd, v.pwd);
      end
      if (!v.we) chk({tag, " busRData"}, rdv, v.erd);
    end
    @(negedge clk);
    if (!keep) begin
      busReq = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0] f3s[5];
    vec_t       v;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1; busReq = 1'b0; busWe = 1'b0; busAddr = '0;
    strb = '0; busWData = '0; s_rd = '0; s_wait = 0; s_err = 1'b0;

    //          we    addr          f3    wd            rd         wait err lat e  erd  psel  pstrb  pwd
    tbl[0]  = '{1'b1, 32'h1000_1004, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 3, 1'b0, 32'h0, 4'b0010, 4'b1111, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 32'h1000_0003, 3'd0, 32'h0, 32'h8000_0000, 2, 1'b0, 5, 1'b0, 32'hFFFF_FF80, 4'b0001, 4'b0000, 32'h0};
    tbl[2]  = '{1'b0, 32'h1000_2002, 3'd5, 32'h0, 32'hABCD_0000, 0, 1'b0, 3, 1'b0, 32'h0000_ABCD, 4'b0100, 4'b0000, 32'h0};
    tbl[3]  = '{1'b1, 32'h1000_2002, 3'd1, 32'h0000_1234, 32'h0, 0, 1'b0, 3, 1'b0, 32'h0, 4'b0100, 4'b1100, 32'h1234_1234};
    tbl[4]  = '{1'b0, 32'h2000_0000, 3'd2, 32'h0, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[5]  = '{1'b0, 32'h1000_0002, 3'd2, 32'h0, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 32'h1000_3000, 3'd2, 32'h0, 32'h1111_1111, 255, 1'b0, 6, 1'b1, 32'h0, 4'b1000, 4'b0000, 32'h0};
    tbl[7]  = '{1'b0, 32'h1000_0008, 3'd2, 32'h0, 32'h7777_7777, 1, 1'b1, 4, 1'b1, 32'h0, 4'b0001, 4'b0000, 32'h0};
    tbl[8]  = '{1'b1, 32'h1000_0001, 3'd0, 32'h0000_00A5, 32'h0, 0, 1'b0, 3, 1'b0, 32'h0, 4'b0001, 4'b0010, 32'hA5A5_A5A5};
    tbl[9]  = '{1'b1, 32'h1000_0000, 3'd4, 32'h0000_0011, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[10] = '{1'b0, 32'h1000_0000, 3'd3, 32'h0, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[11] = '{1'b0, 32'h1000_3002, 3'd1, 32'h0, 32'h8001_7FFF, 0, 1'b0, 3, 1'b0, 32'hFFFF_8001, 4'b1000, 4'b0000, 32'h0};
    tbl[12] = '{1'b0, 32'h0FFF_FFFC, 3'd2, 32'h0, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[13] = '{1'b0, 32'h1000_4000, 3'd2, 32'h0, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[14] = '{1'b0, 32'h1000_3FFC, 3'd2, 32'h0, 32'h1234_5678, 3, 1'b0, 6, 1'b0, 32'h1234_5678, 4'b1000, 4'b0000, 32'h0};
    tbl[15] = '{1'b0, 32'h1000_1002, 3'd4, 32'h0, 32'h00F0_0000, 0, 1'b0, 3, 1'b0, 32'h0000_00F0, 4'b0010, 4'b0000, 32'h0};
    tbl[16] = '{1'b1, 32'h1000_0001, 3'd1, 32'h0000_BEEF, 32'h0, 0, 1'b0, 2, 1'b1, 32'h0, 4'b0000, 4'b0000, 32'h0};
    tbl[17] = '{1'b1, 32'h1000_2010, 3'd2, 32'h0000_0001, 32'h0, 0, 1'b1, 3, 1'b1, 32'h0, 4'b0100, 4'b1111, 32'h0000_0001};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset PSEL", PSEL, 4'b0);
    chk("reset PENABLE", PENABLE, 1'b0);
    chk("reset PWRITE", PWRITE, 1'b0);
    chk("reset PADDR", PADDR, 32'h0);
    chk("reset PWDATA", PWDATA, 32'h0);
    chk("reset PSTRB", PSTRB, 4'b0);
    chk("reset busReady", busReady, 1'b0);
    chk("reset busErr", busErr, 1'b0);
    chk("reset busRData", busRData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Request held high across completions starts the next transfer.
    run_vec(tbl[1], "chainA", 1'b1);
    run_vec(tbl[0], "chainB", 1'b1);
    run_vec(tbl[4], "chainC", 1'b1);
    run_vec(tbl[2], "chainD", 1'b0);

    // Reset in the middle of an access phase.
    busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_1000;
    strb = 3'd2; s_wait = 255; s_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrst in access", PENABLE, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst PSEL", PSEL, 4'b0);
    chk("midrst PENABLE", PENABLE, 1'b0);
    chk("midrst busReady", busReady, 1'b0);
    busReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst quiet%0d", c), {PSEL, busReady}, 5'b0);
    end
    @(negedge clk);
    run_vec(tbl[0], "postrst", 1'b0);

    for (int n = 0; n < 80; n++) begin
      v.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
      else                           v.f3 = f3s[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       v.addr = $urandom;
        1:       v.addr = BASE - 32'(4 * $urandom_range(1, 4));
        default: v.addr = BASE + 32'($urandom_range(0, 4)) * SIZE
                          + 32'($urandom_range(0, 4095));
      endcase
      v.wd     = $urandom;
      v.rd     = $urandom;
      v.waits  = $urandom_range(0, 5);
      v.slverr = ($urandom_range(0, 7) == 0);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n), $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
